// File: rtl/ex_flag_stage.sv
// Execute-to-memory pipeline register with the architectural Z/N flags.
// Resolves BRZ/BRN/JUMP against the pre-edge flags and pulses a redirect to fetch.
module ex_flag_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      alu_out,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             in_valid,
  input  logic [5:0]       in_rd,
  input  logic             in_regwrite,
  input  logic             in_memread,
  input  logic             in_memwrite,
  input  logic             in_memtoreg,
  input  logic             in_setflags,
  input  logic             in_brz,
  input  logic             in_brn,
  input  logic             in_jump,
  input  logic [31:0]      in_target,
  input  logic [31:0]      in_store_data,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [31:0]      out_result,
  output logic [5:0]       out_rd,
  output logic             out_regwrite,
  output logic             out_memread,
  output logic             out_memwrite,
  output logic             out_memtoreg,
  output logic [31:0]      out_store_data,
  output logic             z_flag,
  output logic             n_flag,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_count
);

  // Flags sampled here are the registered values, i.e. from the previous
  // flag-setting instruction, never from the branch itself.
  logic taken;
  assign taken = in_jump | (in_brz & z_flag) | (in_brn & n_flag);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_rd         <= '0;
      out_regwrite   <= 1'b0;
      out_memread    <= 1'b0;
      out_memwrite   <= 1'b0;
      out_memtoreg   <= 1'b0;
      out_store_data <= '0;
      z_flag         <= 1'b0;
      n_flag         <= 1'b0;
      redirect       <= 1'b0;
      redirect_pc    <= '0;
      br_count       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      redirect  <= 1'b0;
    end else if (stall) begin
      // Dropping redirect keeps it a single pulse even if the stage is held.
      redirect <= 1'b0;
    end else if (!in_valid) begin
      out_valid <= 1'b0;
      redirect  <= 1'b0;
    end else begin
      out_valid      <= 1'b1;
      out_result     <= alu_out;
      out_rd         <= in_rd;
      out_regwrite   <= in_regwrite;
      out_memread    <= in_memread;
      out_memwrite   <= in_memwrite;
      out_memtoreg   <= in_memtoreg;
      out_store_data <= in_store_data;
      redirect       <= taken;
      if (taken) begin
        redirect_pc <= in_target;
        br_count    <= br_count + CNT_W'(1);
      end
      if (in_setflags) begin
        z_flag <= alu_z;
        n_flag <= alu_n;
      end
    end
  end

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed bench for ex_flag_stage: flags, branch resolution, stall/flush and counter wrap.
module tb_ex_flag_stage;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      alu_out;
  logic             alu_z, alu_n;
  logic             in_valid;
  logic [5:0]       in_rd;
  logic             in_regwrite, in_memread, in_memwrite, in_memtoreg;
  logic             in_setflags, in_brz, in_brn, in_jump;
  logic [31:0]      in_target, in_store_data;
  logic             stall, flush;
  logic             out_valid;
  logic [31:0]      out_result;
  logic [5:0]       out_rd;
  logic             out_regwrite, out_memread, out_memwrite, out_memtoreg;
  logic [31:0]      out_store_data;
  logic             z_flag, n_flag, redirect;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] br_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_flag_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n),
    .in_valid(in_valid), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .in_memread(in_memread),
    .in_memwrite(in_memwrite), .in_memtoreg(in_memtoreg),
    .in_setflags(in_setflags), .in_brz(in_brz), .in_brn(in_brn), .in_jump(in_jump),
    .in_target(in_target), .in_store_data(in_store_data),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_memread(out_memread),
    .out_memwrite(out_memwrite), .out_memtoreg(out_memtoreg),
    .out_store_data(out_store_data),
    .z_flag(z_flag), .n_flag(n_flag),
    .redirect(redirect), .redirect_pc(redirect_pc), .br_count(br_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_out = '0; alu_z = 0; alu_n = 0;
    in_valid = 0; in_rd = '0;
    in_regwrite = 0; in_memread = 0; in_memwrite = 0; in_memtoreg = 0;
    in_setflags = 0; in_brz = 0; in_brn = 0; in_jump = 0;
    in_target = '0; in_store_data = '0;
    stall = 0; flush = 0;
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #2;

    // Reset with a busy, taken jump at the inputs: nothing may leak through.
    rst = 1; in_valid = 1; in_jump = 1; in_target = 32'hDEAD_0000;
    alu_out = 32'h1234_5678; alu_z = 1; alu_n = 1; in_setflags = 1;
    in_rd = 6'h3F; in_regwrite = 1; in_memread = 1; in_memwrite = 1; in_memtoreg = 1;
    in_store_data = 32'hCAFE_F00D; stall = 1;
    step();
    check("rst out_valid", 32'(out_valid), 0);
    check("rst out_result", out_result, 0);
    check("rst out_rd", 32'(out_rd), 0);
    check("rst ctrl", {28'd0, out_regwrite, out_memread, out_memwrite, out_memtoreg}, 0);
    check("rst store_data", out_store_data, 0);
    check("rst flags", {30'd0, z_flag, n_flag}, 0);
    check("rst redirect", 32'(redirect), 0);
    check("rst redirect_pc", redirect_pc, 0);
    check("rst br_count", 32'(br_count), 0);

    // Zero result sets Z.
    rst = 0; idle_inputs();
    in_valid = 1; in_setflags = 1; alu_out = 0; alu_z = 1; in_rd = 6'd5; in_regwrite = 1;
    step();
    check("zset z_flag", 32'(z_flag), 1);
    check("zset n_flag", 32'(n_flag), 0);
    check("zset out_result", out_result, 0);
    check("zset out_valid", 32'(out_valid), 1);
    check("zset out_rd", 32'(out_rd), 5);

    // Negative result, then a back-to-back BRN.
    idle_inputs();
    in_valid = 1; in_setflags = 1; alu_out = 32'hFFFF_FFFF; alu_n = 1;
    step();
    check("nset n_flag", 32'(n_flag), 1);
    check("nset z_flag", 32'(z_flag), 0);
    check("nset out_result", out_result, 32'hFFFF_FFFF);
    check("nset redirect", 32'(redirect), 0);
    idle_inputs();
    in_valid = 1; in_brn = 1; in_target = 32'h40;
    step();
    check("brn redirect", 32'(redirect), 1);
    check("brn redirect_pc", redirect_pc, 32'h40);
    check("brn br_count", 32'(br_count), 1);
    idle_inputs();
    in_valid = 1; in_target = 32'h80;
    step();
    check("brn pulse end", 32'(redirect), 0);
    check("brn pc hold", redirect_pc, 32'h40);
    check("brn count hold", 32'(br_count), 1);

    // BRZ that also sets Z: evaluates against the old Z=0.
    idle_inputs();
    in_valid = 1; in_brz = 1; in_setflags = 1; alu_z = 1; in_target = 32'h90;
    step();
    check("oldflag redirect", 32'(redirect), 0);
    check("oldflag z_flag", 32'(z_flag), 1);
    check("oldflag n_flag", 32'(n_flag), 0);
    check("oldflag br_count", 32'(br_count), 1);
    check("oldflag pc hold", redirect_pc, 32'h40);

    // Bubble: out_valid drops, flags hold.
    idle_inputs();
    step();
    check("bubble out_valid", 32'(out_valid), 0);
    check("bubble z_flag", 32'(z_flag), 1);

    // Taken jump followed by a 3-cycle stall, from a fresh reset.
    idle_inputs(); rst = 1;
    step();
    rst = 0;
    in_valid = 1; in_jump = 1; in_target = 32'h100; alu_out = 32'h1234;
    in_rd = 6'd7; in_memwrite = 1; in_store_data = 32'hABCD;
    step();
    check("jmp redirect", 32'(redirect), 1);
    check("jmp redirect_pc", redirect_pc, 32'h100);
    check("jmp br_count", 32'(br_count), 1);
    stall = 1; in_target = 32'h200; alu_out = 32'h5555; in_rd = 6'd9; in_memwrite = 0;
    in_store_data = 32'h7777; in_setflags = 1; alu_z = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall redirect", 32'(redirect), 0);
      check("stall out_result", out_result, 32'h1234);
      check("stall out_rd", 32'(out_rd), 7);
      check("stall out_memwrite", 32'(out_memwrite), 1);
      check("stall store_data", out_store_data, 32'hABCD);
      check("stall out_valid", 32'(out_valid), 1);
      check("stall br_count", 32'(br_count), 1);
      check("stall redirect_pc", redirect_pc, 32'h100);
      check("stall z_flag", 32'(z_flag), 0);
    end

    // Set Z, then flush+stall with a taken flag-setting BRZ.
    idle_inputs();
    in_valid = 1; in_setflags = 1; alu_z = 1;
    step();
    check("pre-flush z_flag", 32'(z_flag), 1);
    idle_inputs();
    flush = 1; stall = 1;
    in_valid = 1; in_brz = 1; in_setflags = 1; alu_z = 0; alu_n = 1; in_target = 32'h300;
    step();
    check("flush out_valid", 32'(out_valid), 0);
    check("flush redirect", 32'(redirect), 0);
    check("flush flags", {30'd0, z_flag, n_flag}, 32'b10);
    check("flush br_count", 32'(br_count), 1);
    check("flush redirect_pc", redirect_pc, 32'h100);

    // Counter wrap with CNT_W = 4.
    idle_inputs(); rst = 1;
    step();
    rst = 0;
    for (int k = 1; k <= 17; k++) begin
      in_valid = 1; in_jump = 1; in_target = 32'(k);
      step();
      if (k == 15) check("wrap count 15", 32'(br_count), 15);
      if (k == 16) check("wrap count 16", 32'(br_count), 0);
      if (k == 17) check("wrap count 17", 32'(br_count), 1);
    end
    check("wrap redirect_pc", redirect_pc, 32'd17);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_flag_stage.md
# ex_flag_stage

Pipeline register directly downstream of the ALU. Captures the ALU result and the Z/N outputs together with the instruction's control bits, and keeps the architectural Z/N flag register. Resolves BRZ/BRN/JUMP against those flags and issues a one-cycle redirect to fetch. Feeds the memory/writeback stage.

## Interface
- `CNT_W`, default 16: width of the taken-branch counter.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alu_out` in 32: ALU result for the instruction in this stage's input slot.
- `alu_z`, `alu_n` in 1 each: ALU zero and negative outputs for `alu_out`.
- `in_valid` in 1: the input slot holds a real instruction.
- `in_rd` in 6: destination register.
- `in_regwrite`, `in_memread`, `in_memwrite`, `in_memtoreg` in 1 each: control bits passed through to the next stage.
- `in_setflags` in 1: the instruction is an add/inc/neg/sub ALU op that updates Z/N.
- `in_brz`, `in_brn`, `in_jump` in 1 each: branch-if-zero, branch-if-negative, unconditional jump.
- `in_target` in 32: branch/jump target.
- `in_store_data` in 32: store operand.
- `stall` in 1: hold the stage.
- `flush` in 1: squash the input slot.
- `out_valid` out 1, `out_result` out 32, `out_rd` out 6, `out_regwrite` / `out_memread` / `out_memwrite` / `out_memtoreg` out 1 each, `out_store_data` out 32: registered copies for the next stage.
- `z_flag`, `n_flag` out 1 each: architectural flag register.
- `redirect` out 1: one-cycle taken-branch pulse.
- `redirect_pc` out 32: target that accompanies `redirect`.
- `br_count` out `CNT_W`: number of taken branches/jumps since reset.

## Operation
- Update priority on each rising edge is rst > flush > stall > normal.
- **Reset.** Every output goes to 0: `out_valid`, all `out_*`, `z_flag`, `n_flag`, `redirect`, `redirect_pc`, `br_count`.
- **Flush.**
  - `out_valid` and `redirect` are set to 0.
  - Flags, `br_count` and the `out_*` data fields hold.
  - The squashed instruction has no effect.
- **Stall** (no flush).
  - All registers hold, except `redirect`, which is forced to 0.
  - This guarantees a single redirect pulse per branch even across stall cycles.
- **Normal, `in_valid` = 0.**
  - `out_valid` and `redirect` are set to 0.
  - Flags and `br_count` hold.
  - Data fields may hold.
- **Normal, `in_valid` = 1.**
  - `out_valid` is set to 1 and every `in_*` / `alu_out` field is latched into its `out_*` register.
  - Branch condition: taken = `in_jump` | (`in_brz` & `z_flag`) | (`in_brn` & `n_flag`).
  - The condition uses the flag register value **before** this edge. Flags therefore come from the most recent earlier flag-setting instruction, never from the branch itself.
  - `redirect` is set to taken; `redirect_pc` is set to `in_target` when taken and holds otherwise.
  - If taken, `br_count` increments by 1 modulo 2^`CNT_W`, wrapping from all-ones to 0.
  - If `in_setflags` = 1, `z_flag` is set to `alu_z` and `n_flag` to `alu_n`; otherwise both hold.
  - A single instruction carrying both `in_setflags` and a branch bit evaluates against the old flags, then updates them.
- The `out_*` control bits are not gated by `out_valid`. Consumers must qualify them with `out_valid`.
- No arithmetic is performed here besides the counter. `alu_out` passes through bit-exact.

## Timing
- Latency: 1 cycle from input slot to `out_*`, flags and `redirect`.
- `redirect` is high for exactly one cycle per taken branch. Upstream flushes younger instructions on that cycle.
- A flag-setting instruction in cycle k is visible to a branch presented in cycle k+1 (back-to-back, no bubble).
- `flush` and `stall` asserted together: flush wins and `out_valid` becomes 0.
- `rst` asserted mid-stall or mid-branch: all outputs are 0 on the next edge and no redirect is produced.

## Test plan
- **Reset and flag update.**
  - Assert `rst` with arbitrary inputs: every output is 0 next cycle.
  - Release reset, then present `in_valid` = 1, `in_setflags` = 1, `alu_out` = 0, `alu_z` = 1: next cycle `z_flag` = 1, `n_flag` = 0, `out_result` = 0.
- **Taken BRN on back-to-back flags.**
  - Cycle 1: setflags with `alu_n` = 1, `alu_out` = 0xFFFFFFFF.
  - Cycle 2: `in_brn` = 1, `in_target` = 0x40.
  - Required: `redirect` = 1 for exactly one cycle, `redirect_pc` = 0x40, `br_count` = 1.
- **Old-flag evaluation.**
  - With `z_flag` = 0, present `in_brz` = 1 together with `in_setflags` = 1, `alu_z` = 1.
  - Required: `redirect` = 0, then `z_flag` = 1.
- **Stall after a taken jump.**
  - Present `in_jump` = 1, `in_target` = 0x100, then hold `stall` for 3 cycles.
  - Required: `redirect` high only in the first cycle, `out_*` constant, `br_count` = 1.
- **Flush versus stall.**
  - Assert `flush` and `stall` together with a valid, flag-setting BRZ taken instruction.
  - Required: `out_valid` = 0, `redirect` = 0, flags and `br_count` unchanged.
- **Counter wrap.**
  - Set `CNT_W` = 4 and issue 17 taken jumps.
  - Required: `br_count` reads 15 after the 15th and 1 after the 17th.
